trace_writer: RTL and testbench
===============================

TRACE_WRITER -- requirements
Module: trace_writer

Interface
REQ-001 Parameter DEPTH, default 1024, trace RAM entries (one per display column); SHALL be a power of 2.
REQ-002 Parameter ADDR_W, default 10, RAM address width; SHALL equal log2(DEPTH).
REQ-003 Parameter DECIM, default 4, input samples averaged per written entry; SHALL be a power of 2, 1..64.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  capture enable; low forces IDLE.
REQ-007 sample_in  input  9  signed ECG sample, two's complement.
REQ-008 sample_valid  input  1  sample_in valid this cycle.
REQ-009 sample_ready  output  1  block accepts sample this cycle; transfer = valid and ready.
REQ-010 threshold  input  9  signed trigger level.
REQ-011 rearm  input  1  single-cycle pulse from display side (at vsync) releasing HOLD.
REQ-012 wr_en  output  1  RAM write strobe, one cycle per entry.
REQ-013 wr_adr  output  ADDR_W  RAM write address.
REQ-014 wr_data  output  9  signed averaged sample, same encoding the waveform display consumes.
REQ-015 frame_done  output  1  one-cycle pulse when entry DEPTH-1 is written.
REQ-016 busy  output  1  high in ARMED or CAPTURE.

Function
REQ-017 States IDLE, ARMED, CAPTURE, HOLD; registered state.
REQ-018 IDLE: sample_ready=1, samples discarded; enable high -> ARMED (TRACE_TRIGGER_EN defined) or CAPTURE (undefined).
REQ-019 ARMED: keeps last accepted sample; accepted sample with prev<threshold and cur>=threshold -> CAPTURE, that sample counted as first of first group; first sample after entering ARMED never triggers.
REQ-020 CAPTURE: accumulate accepted samples in signed accumulator of width 9+log2(DECIM); no overflow possible.
REQ-021 On the DECIM-th accepted sample of a group, wr_en SHALL assert the next cycle with wr_data = (sum of group) arithmetically shifted right by log2(DECIM) (floor toward minus infinity); accumulator clears for next group.
REQ-022 wr_adr starts at 0 on each entry into CAPTURE, increments after each write, never wraps within a frame.
REQ-023 Write to address DEPTH-1: frame_done pulses in the same cycle as that wr_en; state -> HOLD.
REQ-024 HOLD: sample_ready=0, no writes; rearm -> ARMED or CAPTURE per REQ-018.
REQ-025 enable low in any state -> IDLE at next edge; partial group and pending address discarded; enable low wins over simultaneous rearm or trigger.
REQ-026 rearm outside HOLD SHALL be ignored.
REQ-027 Throughput: one sample per cycle sustained in ARMED/CAPTURE; sample_valid low cycles pause accumulation without loss.

Reset
REQ-028 Reset asserted: state=IDLE, wr_en=0, wr_adr=0, wr_data=0, frame_done=0, busy=0, sample_ready=0, accumulator and group counter 0, immediately and asynchronously.
REQ-029 sample_ready SHALL rise no earlier than the first clk edge after reset deasserts.
REQ-030 Reset mid-CAPTURE: no further wr_en; RAM contents left as written.

Configuration
REQ-031 Macro TRACE_TRIGGER_EN: defined -> ARMED state and threshold-crossing trigger present; undefined -> ARMED absent, IDLE/HOLD go straight to CAPTURE, threshold unused.

Structure
REQ-032 Shared package trace_pkg: state encoding, DECIM_SHIFT (log2) helper constant, sample width constant (9).
REQ-033 One sub-module trace_decimator: accumulator, group counter, shift, emitting result and strobe; state machine and address stay in trace_writer.

Verification (DEPTH=8, DECIM=4 unless stated)
REQ-034 Macro undefined, enable=1, samples 1,2,3,4,... every cycle -> wr_data 2,6,10,... (floor averages) at wr_adr 0..7, frame_done with eighth write, then sample_ready=0.
REQ-035 Group -1,-2,-2,-2 -> wr_data -2 (floor of -1.75), not -1.
REQ-036 Macro defined, threshold=100, samples 50,90,99,100,... -> first write groups start at the sample 100; earlier samples never written.
REQ-037 Enable dropped after 2 samples of group 3 -> IDLE next edge, no write at adr 2; re-enable restarts at adr 0.
REQ-038 rearm in CAPTURE ignored; rearm in HOLD -> capture resumes, wr_adr 0; rearm with enable=0 same cycle -> IDLE.
REQ-039 Reset asserted mid-frame between clk edges -> wr_en and busy low immediately, no write afterwards.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared state encoding, sample width and decimation shift helper for the trace capture path.
// Used by trace_writer and trace_decimator; the TRACE_TRIGGER_EN option lives in trace_writer.
package trace_pkg;

  localparam int SAMPLE_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  function automatic int decim_shift(input int decim);
    return $clog2(decim);
  endfunction

  localparam int DEFAULT_DECIM = 4;
  localparam int DECIM_SHIFT   = decim_shift(DEFAULT_DECIM);

endpackage

// File: rtl/trace_decimator.sv
// Averages groups of DECIM accepted samples with floor rounding (arithmetic shift of the group sum).
// Latency: out_vld/out_dat register one cycle after a group's last sample; no backpressure, caller gates in_vld.
module trace_decimator
  import trace_pkg::*;
#(
  parameter int DECIM = DEFAULT_DECIM
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_vld,
  input  logic signed [SAMPLE_W-1:0] in_dat,
  output logic                       grp_last,
  output logic                       out_vld,
  output logic signed [SAMPLE_W-1:0] out_dat
);

  localparam int SHIFT = decim_shift(DECIM);
  localparam int ACC_W = SAMPLE_W + SHIFT;
  localparam int CNT_W = (SHIFT > 0) ? SHIFT : 1;

  // Sum of DECIM samples in [-256*DECIM, 255*DECIM] always fits ACC_W signed bits.
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] smp_ext;
  logic signed [ACC_W-1:0] sum;
  logic        [CNT_W-1:0] cnt;

  assign smp_ext  = ACC_W'(in_dat);
  assign sum      = acc + smp_ext;
  assign grp_last = in_vld && (cnt == CNT_W'(DECIM - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      out_vld <= grp_last;
      if (grp_last) begin
        out_dat <= SAMPLE_W'(sum >>> SHIFT);
      end
      if (clear || grp_last) begin
        acc <= '0;
        cnt <= '0;
      end else if (in_vld) begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/trace_writer.sv
// Captures a decimated ECG trace into display RAM, one entry per column; TRACE_TRIGGER_EN adds ARMED with a rising threshold trigger.
// Latency: RAM write one cycle after a group's last sample; sample_ready is low in HOLD and until the first edge after reset.
module trace_writer
  import trace_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DECIM  = DEFAULT_DECIM
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic signed [SAMPLE_W-1:0] threshold,
  input  logic                       rearm,
  output logic                       wr_en,
  output logic        [ADDR_W-1:0]   wr_adr,
  output logic signed [SAMPLE_W-1:0] wr_data,
  output logic                       frame_done,
  output logic                       busy
);

  state_t            state;
  state_t            state_nxt;
  logic              out_of_reset;
  logic              xfer;
  logic              trig;
  logic              acc_vld;
  logic              acc_clr;
  logic              grp_last;
  logic              last_entry;
  logic              capture_entry;
  logic [ADDR_W-1:0] adr_pend;

  assign xfer = sample_valid && sample_ready;

`ifdef TRACE_TRIGGER_EN
  localparam state_t START_ST = ST_ARMED;

  logic signed [SAMPLE_W-1:0] prev;
  logic                       have_prev;

  // prev is only meaningful once a sample has been seen in the current ARMED visit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev      <= '0;
      have_prev <= 1'b0;
    end else if (state != ST_ARMED) begin
      have_prev <= 1'b0;
    end else if (xfer) begin
      prev      <= sample_in;
      have_prev <= 1'b1;
    end
  end

  assign trig = (state == ST_ARMED) && xfer && have_prev &&
                (prev < threshold) && (sample_in >= threshold);
`else
  localparam state_t START_ST = ST_CAPTURE;

  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign trig             = 1'b0;
`endif

  // The trigger sample already belongs to the first group.
  assign acc_vld = enable && xfer && ((state == ST_CAPTURE) || trig);
  assign acc_clr = !enable || ((state != ST_CAPTURE) && !trig);

  trace_decimator #(
    .DECIM (DECIM)
  ) u_decim (
    .clk      (clk),
    .reset    (reset),
    .clear    (acc_clr),
    .in_vld   (acc_vld),
    .in_dat   (sample_in),
    .grp_last (grp_last),
    .out_vld  (wr_en),
    .out_dat  (wr_data)
  );

  // Address the group completing now will land on, counting a write already in flight.
  assign adr_pend      = wr_adr + ADDR_W'(wr_en);
  assign last_entry    = (state == ST_CAPTURE) && grp_last && (adr_pend == ADDR_W'(DEPTH - 1));
  assign capture_entry = (state_nxt == ST_CAPTURE) && (state != ST_CAPTURE);
  assign frame_done    = wr_en && (wr_adr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      out_of_reset <= 1'b0;
    end else begin
      state        <= state_nxt;
      out_of_reset <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = START_ST;
        ST_ARMED:   if (trig) state_nxt = ST_CAPTURE;
        ST_CAPTURE: if (last_entry) state_nxt = ST_HOLD;
        ST_HOLD:    if (rearm) state_nxt = START_ST;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sample_ready = 1'b0;
    busy         = 1'b0;
    case (state)
      ST_IDLE: sample_ready = out_of_reset;
      ST_ARMED, ST_CAPTURE: begin
        sample_ready = out_of_reset;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_adr <= '0;
    end else if (capture_entry) begin
      wr_adr <= '0;
    end else if (wr_en) begin
      wr_adr <= wr_adr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_trace_writer.sv
// Bench for trace_writer (DEPTH=8, DECIM=4): directed steps with random samples against a queue-based reference.
// Runs the matching sequence for builds with and without TRACE_TRIGGER_EN.
module tb_trace_writer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DECIM  = 4;
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_HOLD = 3;
`ifdef TRACE_TRIGGER_EN
  localparam int M_START = M_ARMED;
`else
  localparam int M_START = M_CAP;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic signed [8:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic signed [8:0] threshold;
  logic              rearm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_adr;
  logic signed [8:0] wr_data;
  logic              frame_done;
  logic              busy;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int n_stray = 0;
  int thr_i   = 0;

  int obs_dat[$], obs_adr[$], obs_fd[$], obs_cyc[$];
  int exp_dat[$], exp_adr[$], exp_fd[$], exp_cyc[$];

  int m_st        = M_IDLE;
  int m_grp[$];
  int m_wrote     = 0;
  bit m_have_prev = 1'b0;
  int m_prev      = 0;

  trace_writer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DECIM  (DECIM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .threshold    (threshold),
    .rearm        (rearm),
    .wr_en        (wr_en),
    .wr_adr       (wr_adr),
    .wr_data      (wr_data),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_dat.push_back(int'($signed(wr_data)));
      obs_adr.push_back(int'(wr_adr));
      obs_fd.push_back(int'(frame_done));
      obs_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1 && wr_en !== 1'b1) n_stray++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b, want %b", tag, obs, exp);
  endtask

  function automatic int floor_avg(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return int'($floor(real'(s) / real'(DECIM)));
  endfunction

  function automatic int rnd_smp();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  // Drive one cycle of inputs and advance the reference by the same cycle.
  task automatic step(input bit v, input int d, input bit en, input bit rr);
    int nst;
    sample_valid = v;
    sample_in    = 9'(d);
    enable       = en;
    rearm        = rr;
    nst          = m_st;
    if (!en) begin
      nst = M_IDLE;
      m_grp.delete();
    end else begin
      case (m_st)
        M_IDLE: nst = M_START;
        M_ARMED: if (v) begin
          if (m_have_prev && m_prev < thr_i && d >= thr_i) begin
            nst = M_CAP;
            m_grp.push_back(d);
          end
          m_prev      = d;
          m_have_prev = 1'b1;
        end
        M_CAP: if (v) begin
          m_grp.push_back(d);
          if (m_grp.size() == DECIM) begin
            exp_dat.push_back(floor_avg(m_grp));
            exp_adr.push_back(m_wrote);
            exp_fd.push_back(int'(m_wrote == DEPTH - 1));
            exp_cyc.push_back(cyc + 1);
            m_wrote++;
            m_grp.delete();
            if (m_wrote == DEPTH) nst = M_HOLD;
          end
        end
        M_HOLD: if (rr) nst = M_START;
        default: ;
      endcase
    end
    if (nst == M_ARMED && m_st != M_ARMED) m_have_prev = 1'b0;
    if (nst == M_CAP && m_st != M_CAP) m_wrote = 0;
    m_st = nst;
    @(posedge clk);
    #1;
  endtask

  task automatic random_frame(input int rearm_at);
    for (int i = 0; i < 300 && m_st == M_CAP; i++)
      step($urandom_range(0, 3) != 0, rnd_smp(), 1'b1, i == rearm_at);
    repeat (2) step(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic compare_writes(input string pfx);
    check({pfx, "_count"}, obs_dat.size(), exp_dat.size());
    for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
      check($sformatf("%s_dat%0d", pfx, i), obs_dat[i], exp_dat[i]);
      check($sformatf("%s_adr%0d", pfx, i), obs_adr[i], exp_adr[i]);
      check($sformatf("%s_fd%0d", pfx, i), obs_fd[i], exp_fd[i]);
      check($sformatf("%s_lat%0d", pfx, i), obs_cyc[i], exp_cyc[i]);
    end
    obs_dat.delete(); obs_adr.delete(); obs_fd.delete(); obs_cyc.delete();
    exp_dat.delete(); exp_adr.delete(); exp_fd.delete(); exp_cyc.delete();
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    rearm        = 1'b0;
    threshold    = '0;
    #3;
    check_bit("rst_ready", sample_ready, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_wr_en", wr_en, 1'b0);
    check_bit("rst_frame_done", frame_done, 1'b0);
    check("rst_wr_adr", int'(wr_adr), 0);
    check("rst_wr_data", int'($signed(wr_data)), 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 check_bit("ready_before_edge", sample_ready, 1'b0);
    @(posedge clk);
    #1;
    check_bit("idle_ready", sample_ready, 1'b1);
    check_bit("idle_busy", busy, 1'b0);

`ifndef TRACE_TRIGGER_EN
    // Ramp 1..32 every cycle: floor averages 2,6,...,30.
    step(1'b0, 0, 1'b1, 1'b0);
    check_bit("cap_busy", busy, 1'b1);
    for (int i = 1; i <= 32; i++) step(1'b1, i, 1'b1, 1'b0);
    check_bit("hold_ready", sample_ready, 1'b0);
    check_bit("hold_busy", busy, 1'b0);
    repeat (3) step(1'b1, 99, 1'b1, 1'b0);
    check("ramp_nwr", obs_dat.size(), DEPTH);
    check("ramp_first", obs_dat.size() > 0 ? obs_dat[0] : -999, 2);
    check("ramp_last", obs_dat.size() > 7 ? obs_dat[7] : -999, 30);
    compare_writes("ramp");

    // Rearm from HOLD; negative group rounds toward minus infinity; mid-frame rearm ignored.
    step(1'b0, 0, 1'b1, 1'b1);
    check_bit("rearm_busy", busy, 1'b1);
    step(1'b1, -1, 1'b1, 1'b0);
    step(1'b1, -2, 1'b1, 1'b0);
    step(1'b1, -2, 1'b1, 1'b0);
    step(1'b1, -2, 1'b1, 1'b0);
    random_frame(10);
    check("neg_floor", obs_dat.size() > 0 ? obs_dat[0] : -999, -2);
    compare_writes("rand");

    // Rearm with enable low lands in IDLE, where samples are discarded.
    step(1'b0, 0, 1'b0, 1'b1);
    check_bit("rearm_dis_busy", busy, 1'b0);
    check_bit("rearm_dis_ready", sample_ready, 1'b1);
    repeat (3) step(1'b1, 5, 1'b0, 1'b0);

    // Enable dropped after two samples of the third group.
    step(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, rnd_smp(), 1'b1, 1'b0);
    step(1'b1, 77, 1'b0, 1'b0);
    check_bit("drop_busy", busy, 1'b0);
    repeat (3) step(1'b1, rnd_smp(), 1'b0, 1'b0);
    check("drop_nwr", obs_dat.size(), 2);
    compare_writes("drop");

    step(1'b0, 0, 1'b1, 1'b0);
    random_frame(-1);
    check("reen_adr0", obs_adr.size() > 0 ? obs_adr[0] : -999, 0);
    compare_writes("reen");

    // Reset between edges while a write is on the bus.
    step(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, rnd_smp(), 1'b1, 1'b0);
    check_bit("pre_reset_wr_en", wr_en, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_bit("async_wr_en", wr_en, 1'b0);
    check_bit("async_busy", busy, 1'b0);
    check_bit("async_ready", sample_ready, 1'b0);
    m_st = M_IDLE;
    m_grp.delete();
    exp_dat.delete(); exp_adr.delete(); exp_fd.delete(); exp_cyc.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (4) step(1'b1, rnd_smp(), 1'b0, 1'b0);
    check("post_reset_nwr", obs_dat.size(), 0);
`else
    thr_i     = 100;
    threshold = 9'sd100;
    step(1'b0, 0, 1'b1, 1'b0);
    check_bit("armed_busy", busy, 1'b1);
    check_bit("armed_ready", sample_ready, 1'b1);
    step(1'b1, 50, 1'b1, 1'b0);
    step(1'b1, 90, 1'b1, 1'b0);
    step(1'b1, 99, 1'b1, 1'b0);
    step(1'b1, 100, 1'b1, 1'b0);
    random_frame(-1);
    check("trig_nwr", obs_dat.size(), DEPTH);
    compare_writes("trig");

    // First sample after ARMED never triggers; enable low beats a crossing.
    step(1'b0, 0, 1'b1, 1'b1);
    step(1'b1, 50, 1'b1, 1'b0);
    step(1'b1, 150, 1'b0, 1'b0);
    check_bit("trig_dis_busy", busy, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 120, 1'b1, 1'b0);
    step(1'b1, 130, 1'b1, 1'b0);
    step(1'b1, 20, 1'b1, 1'b0);
    check("armed_nwr", obs_dat.size(), 0);
    step(1'b1, 110, 1'b1, 1'b0);
    random_frame(5);
    compare_writes("retrig");
`endif

    check("stray_frame_done", n_stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
